// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and the framer FSM state type.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_e;

    localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [3:0]  NIB_PREAMBLE   = 4'h5;
    localparam logic [3:0]  NIB_SFD        = 4'hD;

endpackage

// File: rtl/crc32_byte.sv
// Reflected CRC-32 advanced by one byte, LSB first; purely combinational.
module crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC_POLY;
            else                  c = c >> 1;
        end
        crc_o = c;
    end

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles bytes, filters by
// destination address and reports CRC/length/EtherType status per frame.
module mii_rx_framer
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rxd,
    input  logic        rxdv,
    input  logic        rxer,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        ip_valid,
    output logic [10:0] frame_len,
    output state_e      dbg_state
);

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  low_nib_q, low_nib_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        ucast_q, ucast_d;
    logic        bcast_q, bcast_d;
    logic [15:0] etype_q, etype_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        sfd_q, sfd_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sof_q, out_sof_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        ip_q, ip_d;
    logic [10:0] len_q, len_d;

    logic [7:0]  cur_byte;
    logic [31:0] crc_next;
    logic [10:0] byte_inc;
    logic [5:0]  addr_sh;
    logic [47:0] mac_sh;
    logic [47:0] bc_sh;
    logic        frame_good;

    assign cur_byte = {rxd, low_nib_q};

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (cur_byte),
        .crc_o  (crc_next)
    );

    // Address bytes arrive MSB first; shift the wanted byte down to [7:0].
    assign addr_sh  = {3'd5 - byte_cnt_q[2:0], 3'b000};
    assign mac_sh   = MAC_ADDR >> addr_sh;
    assign bc_sh    = BROADCAST_MAC >> addr_sh;
    assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

    assign frame_good = (crc_q == CRC_RESIDUE) && (byte_cnt_q >= MIN_L) &&
                        (byte_cnt_q <= MAX_L) && !err_q && !phase_q && !ovf_q &&
                        (ucast_q || bcast_q);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        low_nib_d   = low_nib_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        ucast_d     = ucast_q;
        bcast_d     = bcast_q;
        etype_d     = etype_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        sfd_d       = sfd_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        ip_d        = 1'b0;
        len_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if (rxdv) begin
                    sfd_d   = 1'b0;
                    state_d = (rxd == NIB_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!rxdv) begin
                    state_d = ST_IDLE;
                end else if (rxd == NIB_SFD) begin
                    state_d    = ST_DATA;
                    phase_d    = 1'b0;
                    byte_cnt_d = '0;
                    crc_d      = CRC_INIT;
                    ucast_d    = 1'b1;
                    bcast_d    = 1'b1;
                    etype_d    = '0;
                    err_d      = 1'b0;
                    ovf_d      = 1'b0;
                    sfd_d      = 1'b1;
                end else if (rxd != NIB_PREAMBLE) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!rxdv) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    len_d   = byte_cnt_q;
                    ok_d    = frame_good;
                    ip_d    = frame_good && (etype_q == ETHERTYPE_IPV4);
                end else begin
                    if (rxer) err_d = 1'b1;
                    if (!phase_q) begin
                        low_nib_d = rxd;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d    = 1'b0;
                        byte_cnt_d = byte_inc;
                        // The overflowing byte is counted but never emitted.
                        if (byte_inc > MAX_L) begin
                            state_d = ST_DROP;
                            ovf_d   = 1'b1;
                        end else begin
                            out_valid_d = 1'b1;
                            out_data_d  = cur_byte;
                            out_sof_d   = (byte_cnt_q == 11'd0);
                            crc_d       = crc_next;
                            if (byte_cnt_q < 11'd6) begin
                                ucast_d = ucast_q && (cur_byte == mac_sh[7:0]);
                                bcast_d = bcast_q && (cur_byte == bc_sh[7:0]);
                            end
                            if (byte_cnt_q == 11'd12) etype_d[15:8] = cur_byte;
                            if (byte_cnt_q == 11'd13) etype_d[7:0]  = cur_byte;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!rxdv) begin
                    state_d = ST_IDLE;
                    if (sfd_q) begin
                        done_d = 1'b1;
                        len_d  = byte_cnt_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            low_nib_q   <= '0;
            byte_cnt_q  <= '0;
            crc_q       <= CRC_INIT;
            ucast_q     <= 1'b0;
            bcast_q     <= 1'b0;
            etype_q     <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sfd_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            ip_q        <= 1'b0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            low_nib_q   <= low_nib_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            ucast_q     <= ucast_d;
            bcast_q     <= bcast_d;
            etype_q     <= etype_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            sfd_q       <= sfd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            ip_q        <= ip_d;
            len_q       <= len_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign ip_valid   = ip_q;
    assign frame_len  = len_q;
    assign dbg_state  = state_q;

endmodule
